ecc_apb_regfile: RTL

//   APB slave register file driving the ECC controller: the host writes CTRL/DATA_IN/CODEWORD_WIDTH/NOISE here.
//   The block pulses CTRL_ready to start an operation and captures data_out/num_of_errors on operation_done.
//   It tracks busy/done/timeout status for host polling. Sits between the APB bus and the controller.

---
 rtl/ecc_regs_pkg.sv | 35 +++
 rtl/ecc_apb_regfile_if.sv | 24 ++
 rtl/ecc_op_tracker.sv | 102 ++++++++++
 rtl/ecc_apb_regfile.sv | 135 +++++++++++++
 4 files changed

// File: rtl/ecc_regs_pkg.sv
// Shared definitions for the ECC controller APB register file: register
// byte offsets, operation FSM encoding, STATUS bit positions and CTRL modes.
package ecc_regs_pkg;

    // Byte offsets inside the 32-byte register window (PADDR[4:0]).
    localparam logic [4:0] CTRL_OFS     = 5'h00;
    localparam logic [4:0] DATA_IN_OFS  = 5'h04;
    localparam logic [4:0] CW_OFS       = 5'h08;
    localparam logic [4:0] NOISE_OFS    = 5'h0C;
    localparam logic [4:0] DATA_OUT_OFS = 5'h10;
    localparam logic [4:0] NUM_ERR_OFS  = 5'h14;
    localparam logic [4:0] STATUS_OFS   = 5'h18;
    localparam logic [4:0] RSVD_OFS     = 5'h1C;

    // STATUS register bit positions.
    localparam int STAT_BUSY    = 0;
    localparam int STAT_DONE    = 1;
    localparam int STAT_TIMEOUT = 2;
    localparam int STATUS_W     = 3;

    typedef enum logic [1:0] {
        OP_IDLE  = 2'd0,
        OP_START = 2'd1,
        OP_BUSY  = 2'd2
    } op_state_e;

    // CTRL[1:0] operating modes; MODE_RSVD is stored but never starts an operation.
    typedef enum logic [1:0] {
        MODE_ENC  = 2'd0,
        MODE_DEC  = 2'd1,
        MODE_FULL = 2'd2,
        MODE_RSVD = 2'd3
    } ctrl_mode_e;

endpackage

// File: rtl/ecc_apb_regfile_if.sv
// APB3 bus bundle between a host master and the ECC register file slave.
interface ecc_apb_regfile_if #(
    parameter int ADDR_W    = 8,
    parameter int AMBA_WORD = 32
);
    logic [ADDR_W-1:0]    PADDR;
    logic                 PSEL;
    logic                 PENABLE;
    logic                 PWRITE;
    logic [AMBA_WORD-1:0] PWDATA;
    logic [AMBA_WORD-1:0] PRDATA;
    logic                 PREADY;
    logic                 PSLVERR;

    modport master (
        output PADDR, PSEL, PENABLE, PWRITE, PWDATA,
        input  PRDATA, PREADY, PSLVERR
    );

    modport slave (
        input  PADDR, PSEL, PENABLE, PWRITE, PWDATA,
        output PRDATA, PREADY, PSLVERR
    );
endinterface

// File: rtl/ecc_op_tracker.sv
// Operation tracker: IDLE -> START -> BUSY -> IDLE sequencing, the
// watchdog counter, done/timeout flags and capture of controller results.
module ecc_op_tracker
    import ecc_regs_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int TIMEOUT    = 64
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start_i,
    input  logic                  operation_done_i,
    input  logic [DATA_WIDTH-1:0] data_out_i,
    input  logic [1:0]            num_of_errors_i,
    output logic                  ctrl_ready_o,
    output logic                  idle_o,
    output logic [STATUS_W-1:0]   status_o,
    output logic [DATA_WIDTH-1:0] result_o,
    output logic [1:0]            errors_o
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);

    op_state_e             state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic                  done_q, done_d;
    logic                  tmo_q, tmo_d;
    logic [DATA_WIDTH-1:0] result_q, result_d;
    logic [1:0]            errors_q, errors_d;

    // Next-state logic; BUSY lasts at most TIMEOUT cycles, and a completion on the final one beats the timeout.
    always_comb begin
        // NOTE: every _d starts as its _q so no branch can leave a latch behind.
        state_d  = state_q;
        cnt_d    = cnt_q;
        done_d   = done_q;
        tmo_d    = tmo_q;
        result_d = result_q;
        errors_d = errors_q;
        unique case (state_q)
            OP_IDLE: begin
                if (start_i) state_d = OP_START;
            end
            OP_START: begin
                done_d  = 1'b0;
                tmo_d   = 1'b0;
                cnt_d   = CNT_W'(TIMEOUT);
                state_d = OP_BUSY;
            end
            OP_BUSY: begin
                if (operation_done_i) begin
                    result_d = data_out_i;
                    errors_d = num_of_errors_i;
                    done_d   = 1'b1;
                    state_d  = OP_IDLE;
                end else if (cnt_q == CNT_W'(1)) begin
                    // Counter would reach zero this cycle: give up, keep old results.
                    cnt_d   = '0;
                    tmo_d   = 1'b1;
                    state_d = OP_IDLE;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: state_d = OP_IDLE;
        endcase
    end

    // State and result registers.
    always_ff @(posedge clk or negedge reset) begin
        // NOTE: non-blocking updates with an asynchronous reset; CTRL_ready falls the moment reset asserts.
        if (!reset) begin
            state_q  <= OP_IDLE;
            cnt_q    <= '0;
            done_q   <= 1'b0;
            tmo_q    <= 1'b0;
            result_q <= '0;
            errors_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            done_q   <= done_d;
            tmo_q    <= tmo_d;
            result_q <= result_d;
            errors_q <= errors_d;
        end
    end

    assign ctrl_ready_o = (state_q == OP_START);
    assign idle_o       = (state_q == OP_IDLE);
    assign result_o     = result_q;
    assign errors_o     = errors_q;

    // Host-visible status word.
    always_comb begin
        status_o               = '0;
        status_o[STAT_BUSY]    = (state_q != OP_IDLE);
        status_o[STAT_DONE]    = done_q;
        status_o[STAT_TIMEOUT] = tmo_q;
    end

endmodule

// File: rtl/ecc_apb_regfile.sv
// APB slave register file in front of the ECC controller. Holds the config
// registers, decodes APB reads/writes and launches operations via the tracker.
// Optional feature: define ECC_PSLVERR_EN to report illegal accesses on PSLVERR.
module ecc_apb_regfile
    import ecc_regs_pkg::*;
#(
    parameter int AMBA_WORD  = 32,
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_W     = 8,
    parameter int TIMEOUT    = 64
) (
    input  logic                  clk,
    input  logic                  reset,
    ecc_apb_regfile_if.slave      apb,
    output logic [AMBA_WORD-1:0]  CTRL,
    output logic [AMBA_WORD-1:0]  DATA_IN,
    output logic [AMBA_WORD-1:0]  CODEWORD_WIDTH,
    output logic [AMBA_WORD-1:0]  NOISE,
    output logic                  CTRL_ready,
    input  logic [DATA_WIDTH-1:0] data_out,
    input  logic                  operation_done,
    input  logic [1:0]            num_of_errors
);

    logic [4:0]            ofs;
    logic                  addr_ok, cfg_sel, setup, access, op_idle, wr_ok, start;
    logic [STATUS_W-1:0]   status;
    logic [DATA_WIDTH-1:0] result;
    logic [1:0]            errors;
    logic [AMBA_WORD-1:0]  rd_data;
    logic                  unused_addr_lsb;

    logic [AMBA_WORD-1:0] ctrl_q, ctrl_d, din_q, din_d, cw_q, cw_d, noise_q, noise_d;
    logic [AMBA_WORD-1:0] prdata_q, prdata_d;

    assign ofs             = {apb.PADDR[4:2], 2'b00};
    assign addr_ok         = (apb.PADDR[ADDR_W-1:5] == '0);
    assign cfg_sel         = ~apb.PADDR[4];
    assign unused_addr_lsb = ^apb.PADDR[1:0];
    assign setup           = apb.PSEL & ~apb.PENABLE;
    assign access          = apb.PSEL & apb.PENABLE;

    // Config writes only land while no operation is in flight.
    assign wr_ok = access & apb.PWRITE & addr_ok & cfg_sel & op_idle;
    assign start = wr_ok & (ofs == CTRL_OFS) & (apb.PWDATA[1:0] != MODE_RSVD);

    ecc_op_tracker #(
        .DATA_WIDTH (DATA_WIDTH),
        .TIMEOUT    (TIMEOUT)
    ) u_tracker (
        .clk              (clk),
        .reset            (reset),
        .start_i          (start),
        .operation_done_i (operation_done),
        .data_out_i       (data_out),
        .num_of_errors_i  (num_of_errors),
        .ctrl_ready_o     (CTRL_ready),
        .idle_o           (op_idle),
        .status_o         (status),
        .result_o         (result),
        .errors_o         (errors)
    );

    // Config register next-state from accepted APB writes.
    always_comb begin
        ctrl_d  = ctrl_q;
        din_d   = din_q;
        cw_d    = cw_q;
        noise_d = noise_q;
        if (wr_ok) begin
            case (ofs)
                CTRL_OFS:    ctrl_d  = apb.PWDATA;
                DATA_IN_OFS: din_d   = apb.PWDATA;
                CW_OFS:      cw_d    = apb.PWDATA;
                NOISE_OFS:   noise_d = apb.PWDATA;
                default:     ;
            endcase
        end
    end

    // Read mux; out-of-window addresses read as zero.
    always_comb begin
        rd_data = '0;
        if (addr_ok) begin
            case (ofs)
                CTRL_OFS:     rd_data = ctrl_q;
                DATA_IN_OFS:  rd_data = din_q;
                CW_OFS:       rd_data = cw_q;
                NOISE_OFS:    rd_data = noise_q;
                DATA_OUT_OFS: rd_data = AMBA_WORD'(result);
                NUM_ERR_OFS:  rd_data = AMBA_WORD'(errors);
                STATUS_OFS:   rd_data = AMBA_WORD'(status);
                default:      rd_data = '0;
            endcase
        end
    end

    // PRDATA is captured in the setup phase and held through the access phase.
    always_comb begin
        prdata_d = setup ? rd_data : prdata_q;
    end

    // Register bank and read-data register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ctrl_q   <= '0;
            din_q    <= '0;
            cw_q     <= '0;
            noise_q  <= '0;
            prdata_q <= '0;
        end else begin
            ctrl_q   <= ctrl_d;
            din_q    <= din_d;
            cw_q     <= cw_d;
            noise_q  <= noise_d;
            prdata_q <= prdata_d;
        end
    end

    assign CTRL           = ctrl_q;
    assign DATA_IN        = din_q;
    assign CODEWORD_WIDTH = cw_q;
    assign NOISE          = noise_q;

    assign apb.PRDATA = prdata_q;
    assign apb.PREADY = access;

`ifdef ECC_PSLVERR_EN
    // Flag out-of-window accesses, writes to read-only offsets, and config writes mid-operation.
    assign apb.PSLVERR = access & (~addr_ok | (apb.PWRITE & (~cfg_sel | ~op_idle)));
`else
    assign apb.PSLVERR = 1'b0;
`endif

endmodule
